// File: rtl/controle_entrada.sv
// controle_entrada: responder side of the input-instruction handshake (opcode 19).
// Synchronizes and debounces the confirm button, latches the switch word on a fresh
// press and answers the control unit with estagioEntradaSwitch, then estagioEntradaBanco.
//
// Ports:
//   clock                 system clock, rising edge
//   reset                 asynchronous, active-high; clears all state
//   estagioEntradaUC      request from the control unit, held while opcode 19 is decoded
//   botaoConfirma         raw asynchronous confirm push-button (active-high)
//   switches              raw switch levels, sampled only in the capture cycle
//   dadoEntrada           latched switch word, zero-extended to DATA_WIDTH
//   estagioEntradaSwitch  data valid (CAPTURA and CONFIRMA)
//   estagioEntradaBanco   single-cycle register-write / PC-release pulse (CONFIRMA)
module controle_entrada #(
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEBOUNCE_CICLOS = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  estagioEntradaUC,
  input  logic                  botaoConfirma,
  input  logic [SW_WIDTH-1:0]   switches,
  output logic [DATA_WIDTH-1:0] dadoEntrada,
  output logic                  estagioEntradaSwitch,
  output logic                  estagioEntradaBanco
);

  localparam int unsigned CntWidth = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DEBOUNCE_CICLOS - 1);

  localparam logic [2:0] OCIOSO       = 3'd0;
  localparam logic [2:0] ESPERA_SOLTA = 3'd1;
  localparam logic [2:0] ESPERA_BOTAO = 3'd2;
  localparam logic [2:0] CAPTURA      = 3'd3;
  localparam logic [2:0] CONFIRMA     = 3'd4;
  localparam logic [2:0] FIM          = 3'd5;

  logic [1:0]            syncQ;
  logic                  estavelQ, estavelD;
  logic [CntWidth-1:0]   contadorQ, contadorD;
  logic                  evPress;
  logic [2:0]            estadoQ, estadoD;
  logic [DATA_WIDTH-1:0] dadoQ, dadoD;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncQ <= 2'b00;
    end else begin
      syncQ <= {syncQ[0], botaoConfirma};
    end
  end

  // Debouncer: the stable level only follows the synced level after it has
  // differed for DEBOUNCE_CICLOS consecutive cycles. evPress fires in the cycle
  // the stable level flips 0->1, so the FSM sees it together with the flip.
  always_comb begin
    estavelD  = estavelQ;
    contadorD = '0;
    evPress   = 1'b0;
    if (syncQ[1] != estavelQ) begin
      if (contadorQ == CntMax) begin
        estavelD = syncQ[1];
        evPress  = syncQ[1];
      end else begin
        contadorD = contadorQ + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estavelQ  <= 1'b0;
      contadorQ <= '0;
    end else begin
      estavelQ  <= estavelD;
      contadorQ <= contadorD;
    end
  end

  always_comb begin
    estadoD = estadoQ;
    dadoD   = dadoQ;
    unique case (estadoQ)
      OCIOSO: begin
        if (estagioEntradaUC) estadoD = ESPERA_SOLTA;
      end
      // A press still held from an earlier instruction must be released first.
      ESPERA_SOLTA: begin
        if (!estagioEntradaUC)  estadoD = OCIOSO;
        else if (!estavelQ)     estadoD = ESPERA_BOTAO;
      end
      ESPERA_BOTAO: begin
        if (!estagioEntradaUC) begin
          estadoD = OCIOSO;
        end else if (evPress) begin
          dadoD   = DATA_WIDTH'(switches);
          estadoD = CAPTURA;
        end
      end
      CAPTURA:  estadoD = CONFIRMA;
      CONFIRMA: estadoD = FIM;
      // Hold here until the request drops so one instruction gets one acknowledge.
      FIM: begin
        if (!estagioEntradaUC) estadoD = OCIOSO;
      end
      default: estadoD = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estadoQ <= OCIOSO;
      dadoQ   <= '0;
    end else begin
      estadoQ <= estadoD;
      dadoQ   <= dadoD;
    end
  end

  // Decoded straight from the state register so reset drops them immediately.
  assign estagioEntradaSwitch = (estadoQ == CAPTURA) || (estadoQ == CONFIRMA);
  assign estagioEntradaBanco  = (estadoQ == CONFIRMA);
  assign dadoEntrada          = dadoQ;

endmodule
